// File: rtl/bcd_counter_pkg.sv
// Shared definitions for the N-digit BCD up/down counter.
// Holds the digit and segment widths, the 7-segment codes and the
// BCD-to-segment decode used by bcd_updn_counter_n.
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
package bcd_counter_pkg;

    localparam int SEG_W = 7;
    localparam int BCD_W = 4;

    localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    // Codes A-F never occur in a healthy counter; they show as blank.
    function automatic logic [SEG_W-1:0] bcd_to_seg(input logic [BCD_W-1:0] bcd);
        logic [SEG_W-1:0] seg;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/btn_sync_debounce.sv
// Per-button input conditioning: two-flop synchroniser, debounce counter
// and an edge register on the accepted level.
// Ports:
//   clk_i    system clock (rising edge)
//   rst_i    synchronous active-high reset
//   btn_i    raw asynchronous button level
//   level_o  accepted (debounced) level
//   rise_o   one-cycle pulse when the accepted level goes 0->1
//   fall_o   one-cycle pulse when the accepted level goes 1->0
// Parameter DB_CYCLES: consecutive differing synchronised samples needed
// before the accepted level follows the button.
module btn_sync_debounce #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             prev_q;

    // Debounce next state: count consecutive samples that disagree with the
    // accepted level; the DB_CYCLES-th such sample is the one that is adopted.
    always_comb begin
        level_d = level_q;
        cnt_d   = CNT_ZERO;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                cnt_d   = CNT_ZERO;
            end else begin
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = CNT_ZERO;
        end
    end

    // Synchroniser, debounce state and edge register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= CNT_ZERO;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            prev_q  <= level_q;
        end
    end

    assign level_o = level_q;
    assign rise_o  = level_q & ~prev_q;
    assign fall_o  = ~level_q & prev_q;

endmodule

// File: rtl/bcd_updn_counter_n.sv
// N-digit BCD up/down event counter driven by two push buttons.
// A debounced press of i_Push counts by one in the current direction; a
// debounced release of i_Toggle flips the direction.
// Ports:
//   i_Clk     system clock (rising edge)
//   i_Rst     synchronous active-high reset
//   i_Push    raw count button (asynchronous)
//   i_Toggle  raw mode button (asynchronous, release toggles mode)
//   o_LED     BCD value, digit k in [4k+3:4k]
//   o_FND     7-segment codes {g,f,e,d,c,b,a}, digit k in [7k+6:7k]
//   o_Mode    0 = up, 1 = down
//   o_Wrap    one-cycle pulse after the whole counter wraps
// Build option: define SATURATE_EN to hold at all-9s (up) / all-0s (down)
// instead of wrapping; o_Wrap then never fires.
module bcd_updn_counter_n
    import bcd_counter_pkg::*;
#(
    parameter int DIGITS    = 3,
    parameter int DB_CYCLES = 16
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst,
    input  logic                    i_Push,
    input  logic                    i_Toggle,
    output logic [BCD_W*DIGITS-1:0] o_LED,
    output logic [SEG_W*DIGITS-1:0] o_FND,
    output logic                    o_Mode,
    output logic                    o_Wrap
);

    logic                    push_level_s;
    logic                    push_rise_s;
    logic                    push_fall_s;
    logic                    tog_level_s;
    logic                    tog_rise_s;
    logic                    tog_fall_s;
    logic                    unused_s;

    logic [BCD_W*DIGITS-1:0] led_q;
    logic [BCD_W*DIGITS-1:0] led_d;
    logic [BCD_W*DIGITS-1:0] nxt_s;
    logic                    top_cy_s;
    logic                    mode_q;
    logic                    mode_d;
    logic                    wrap_q;
    logic                    wrap_d;

    btn_sync_debounce #(.DB_CYCLES(DB_CYCLES)) u_push_db (
        .clk_i   (i_Clk),
        .rst_i   (i_Rst),
        .btn_i   (i_Push),
        .level_o (push_level_s),
        .rise_o  (push_rise_s),
        .fall_o  (push_fall_s)
    );

    btn_sync_debounce #(.DB_CYCLES(DB_CYCLES)) u_tog_db (
        .clk_i   (i_Clk),
        .rst_i   (i_Rst),
        .btn_i   (i_Toggle),
        .level_o (tog_level_s),
        .rise_o  (tog_rise_s),
        .fall_o  (tog_fall_s)
    );

    // Only the push rise and toggle fall pulses drive the counter.
    assign unused_s = push_level_s ^ push_fall_s ^ tog_level_s ^ tog_rise_s;

    // Digit chain: each stage sees a carry/borrow request from the stage
    // below (digit 0 from the push pulse) and passes one upward when it rolls
    // over, so the whole ripple settles within one cycle.
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        logic [BCD_W-1:0] dig_s;
        logic [BCD_W-1:0] nxt_dig_s;
        logic             cy_in_s;
        logic             cy_out_s;

        assign dig_s = led_q[BCD_W*k +: BCD_W];

        if (k == 0) begin : g_first
            assign cy_in_s = push_rise_s;
        end else begin : g_chain
            assign cy_in_s = g_digit[k-1].cy_out_s;
        end

        // Single-digit increment/decrement with roll-over detection.
        always_comb begin
            nxt_dig_s = dig_s;
            cy_out_s  = 1'b0;
            if (cy_in_s) begin
                if (mode_q == 1'b0) begin
                    if (dig_s == 4'd9) begin
                        nxt_dig_s = 4'd0;
                        cy_out_s  = 1'b1;
                    end else begin
                        nxt_dig_s = dig_s + 4'd1;
                    end
                end else begin
                    if (dig_s == 4'd0) begin
                        nxt_dig_s = 4'd9;
                        cy_out_s  = 1'b1;
                    end else begin
                        nxt_dig_s = dig_s - 4'd1;
                    end
                end
            end else begin
                nxt_dig_s = dig_s;
            end
        end

        assign nxt_s[BCD_W*k +: BCD_W] = nxt_dig_s;
        assign o_FND[SEG_W*k +: SEG_W] = bcd_to_seg(dig_s);
    end

    // A carry out of the top digit means the whole counter rolled over.
    assign top_cy_s = g_digit[DIGITS-1].cy_out_s;

    // Counter, mode and wrap-flag next state. The count uses the mode held
    // in mode_q, so a toggle landing in the same cycle only affects later
    // counts.
    always_comb begin
        led_d  = nxt_s;
        wrap_d = 1'b0;
        mode_d = mode_q ^ tog_fall_s;
`ifdef SATURATE_EN
        if (top_cy_s) begin
            led_d = led_q;
        end else begin
            led_d = nxt_s;
        end
        wrap_d = 1'b0;
`else
        wrap_d = top_cy_s;
`endif
    end

    // Counter, mode and wrap-flag registers.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            led_q  <= {(BCD_W*DIGITS){1'b0}};
            mode_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            led_q  <= led_d;
            mode_q <= mode_d;
            wrap_q <= wrap_d;
        end
    end

    assign o_LED  = led_q;
    assign o_Mode = mode_q;
    assign o_Wrap = wrap_q;

endmodule

// File: tb/tb_bcd_updn_counter_n.sv
// Self-checking bench for bcd_updn_counter_n with DIGITS=3, DB_CYCLES=4.
// Table-driven press/toggle vectors plus hand-written latency, bounce,
// wrap, simultaneous-pulse and reset sequences. Honours SATURATE_EN.
module tb_bcd_updn_counter_n;

    localparam int DIGITS    = 3;
    localparam int DB_CYCLES = 4;

    logic        i_Clk = 1'b0;
    logic        i_Rst = 1'b1;
    logic        i_Push = 1'b0;
    logic        i_Toggle = 1'b0;
    logic [11:0] o_LED;
    logic [20:0] o_FND;
    logic        o_Mode;
    logic        o_Wrap;

    int n_tests = 0;
    int n_fail  = 0;
    int wrap_cnt = 0;

    bcd_updn_counter_n #(.DIGITS(DIGITS), .DB_CYCLES(DB_CYCLES)) dut (
        .i_Clk    (i_Clk),
        .i_Rst    (i_Rst),
        .i_Push   (i_Push),
        .i_Toggle (i_Toggle),
        .o_LED    (o_LED),
        .o_FND    (o_FND),
        .o_Mode   (o_Mode),
        .o_Wrap   (o_Wrap)
    );

    always #5 i_Clk = ~i_Clk;

    typedef struct {
        logic        is_toggle;
        logic [11:0] led;
        logic        mode;
        int          wraps;
    } vec_t;

    vec_t tbl [10];

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [20:0] fnd_of(input logic [11:0] led);
        return {seg_of(led[11:8]), seg_of(led[7:4]), seg_of(led[3:0])};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to the next falling edge; outputs are stable there.
    task automatic tick();
        @(negedge i_Clk);
        if (o_Wrap) wrap_cnt++;
    endtask

    task automatic do_reset();
        i_Rst = 1'b1;
        i_Push = 1'b0;
        i_Toggle = 1'b0;
        repeat (3) tick();
        i_Rst = 1'b0;
        repeat (2) tick();
        wrap_cnt = 0;
    endtask

    task automatic press();
        i_Push = 1'b1;
        repeat (8) tick();
        i_Push = 1'b0;
        repeat (8) tick();
    endtask

    task automatic toggle_mode();
        i_Toggle = 1'b1;
        repeat (8) tick();
        i_Toggle = 1'b0;
        repeat (8) tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
`ifdef SATURATE_EN
        tbl[0] = '{1'b0, 12'h001, 1'b0, 0};
        tbl[1] = '{1'b0, 12'h002, 1'b0, 0};
        tbl[2] = '{1'b1, 12'h002, 1'b1, 0};
        tbl[3] = '{1'b0, 12'h001, 1'b1, 0};
        tbl[4] = '{1'b0, 12'h000, 1'b1, 0};
        tbl[5] = '{1'b0, 12'h000, 1'b1, 0};
        tbl[6] = '{1'b0, 12'h000, 1'b1, 0};
        tbl[7] = '{1'b1, 12'h000, 1'b0, 0};
        tbl[8] = '{1'b0, 12'h001, 1'b0, 0};
        tbl[9] = '{1'b0, 12'h002, 1'b0, 0};
`else
        tbl[0] = '{1'b0, 12'h001, 1'b0, 0};
        tbl[1] = '{1'b0, 12'h002, 1'b0, 0};
        tbl[2] = '{1'b1, 12'h002, 1'b1, 0};
        tbl[3] = '{1'b0, 12'h001, 1'b1, 0};
        tbl[4] = '{1'b0, 12'h000, 1'b1, 0};
        tbl[5] = '{1'b0, 12'h999, 1'b1, 1};
        tbl[6] = '{1'b0, 12'h998, 1'b1, 0};
        tbl[7] = '{1'b1, 12'h998, 1'b0, 0};
        tbl[8] = '{1'b0, 12'h999, 1'b0, 0};
        tbl[9] = '{1'b0, 12'h000, 1'b0, 1};
`endif

        // Reset state
        do_reset();
        check("rst_led",  32'(o_LED), 32'h000);
        check("rst_fnd",  32'(o_FND), 32'({3{7'h3F}}));
        check("rst_mode", 32'(o_Mode), 32'h0);
        check("rst_wrap", 32'(o_Wrap), 32'h0);

        // Latency: push seen at edge E, count visible at edge E+6
        i_Push = 1'b1;
        repeat (6) tick();
        check("lat_e5",  32'(o_LED), 32'h000);
        tick();
        check("lat_e6",  32'(o_LED), 32'h001);
        repeat (3) tick();
        check("lat_hold", 32'(o_LED), 32'h001);
        i_Push = 1'b0;
        repeat (10) tick();
        check("lat_release", 32'(o_LED), 32'h001);
        // Too-short press
        i_Push = 1'b1;
        repeat (3) tick();
        i_Push = 1'b0;
        repeat (12) tick();
        check("short_press", 32'(o_LED), 32'h001);

        // Bounce then stable high: one increment, 6 edges after final rise
        for (int i = 0; i < 5; i++) begin
            i_Push = 1'b1;
            repeat (2) tick();
            i_Push = 1'b0;
            repeat (2) tick();
        end
        i_Push = 1'b1;
        repeat (6) tick();
        check("bounce_e5", 32'(o_LED), 32'h001);
        tick();
        check("bounce_e6", 32'(o_LED), 32'h002);
        repeat (8) tick();
        i_Push = 1'b0;
        repeat (10) tick();
        check("bounce_once", 32'(o_LED), 32'h002);

        // Table-driven press/toggle sequence from reset
        do_reset();
        for (int i = 0; i < 10; i++) begin
            wrap_cnt = 0;
            if (tbl[i].is_toggle) toggle_mode();
            else press();
            check($sformatf("vec%0d_led", i),  32'(o_LED),  32'(tbl[i].led));
            check($sformatf("vec%0d_fnd", i),  32'(o_FND),  32'(fnd_of(tbl[i].led)));
            check($sformatf("vec%0d_mode", i), 32'(o_Mode), 32'(tbl[i].mode));
            check($sformatf("vec%0d_wrap", i), 32'(wrap_cnt), 32'(tbl[i].wraps));
        end

        // Down across a digit boundary: 100 -> 099
        do_reset();
        repeat (100) press();
        check("up_to_100", 32'(o_LED), 32'h100);
        toggle_mode();
        wrap_cnt = 0;
        press();
        check("down_100", 32'(o_LED), 32'h099);
        check("down_100_wrap", 32'(wrap_cnt), 32'h0);

        // Preload to 999 then one more up count
        do_reset();
        repeat (999) press();
        check("pre_999", 32'(o_LED), 32'h999);
        check("pre_999_wraps", 32'(wrap_cnt), 32'h0);
        wrap_cnt = 0;
        press();
`ifdef SATURATE_EN
        check("up_999_led",  32'(o_LED), 32'h999);
        check("up_999_fnd",  32'(o_FND), 32'(fnd_of(12'h999)));
        check("up_999_wrap", 32'(wrap_cnt), 32'h0);
`else
        check("up_999_led",  32'(o_LED), 32'h000);
        check("up_999_fnd",  32'(o_FND), 32'(fnd_of(12'h000)));
        check("up_999_wrap", 32'(wrap_cnt), 32'h1);
`endif

        // Push rise and toggle fall pulses in the same cycle at 005
        do_reset();
        repeat (5) press();
        check("sim_pre", 32'(o_LED), 32'h005);
        i_Toggle = 1'b1;
        repeat (10) tick();
        i_Push = 1'b1;
        i_Toggle = 1'b0;
        repeat (6) tick();
        check("sim_e5_led",  32'(o_LED), 32'h005);
        check("sim_e5_mode", 32'(o_Mode), 32'h0);
        tick();
        check("sim_e6_led",  32'(o_LED), 32'h006);
        check("sim_e6_mode", 32'(o_Mode), 32'h1);
        i_Push = 1'b0;
        repeat (10) tick();

        // Reset mid-debounce
        i_Push = 1'b1;
        repeat (3) tick();
        i_Rst = 1'b1;
        tick();
        i_Push = 1'b0;
        repeat (2) tick();
        i_Rst = 1'b0;
        wrap_cnt = 0;
        tick();
        check("mid_rst_led",  32'(o_LED), 32'h000);
        check("mid_rst_fnd",  32'(o_FND), 32'({3{7'h3F}}));
        check("mid_rst_mode", 32'(o_Mode), 32'h0);
        check("mid_rst_wrap", 32'(o_Wrap), 32'h0);
        repeat (20) tick();
        check("mid_rst_nocount", 32'(o_LED), 32'h000);
        check("mid_rst_nowrap", 32'(wrap_cnt), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
